// File: rtl/dmux_pkg.sv
// Shared constants for the 4-channel serial deserializer.
package dmux_pkg;

  localparam int NCH       = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 8;

  // Bit-counter width for a given word width; at least one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/dmux_deser_lane.sv
// One deserializer channel: LSB-first shift register, bit counter,
// one-deep holding register with valid/ready, sticky overrun flag.
module dmux_deser_lane
  import dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             i,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] word;
  logic             done;

  assign word = {i, shreg_q[WIDTH-1:1]};
  assign done = bit_en && (cnt_q == LAST);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (bit_en) begin
      if (done) begin
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = word;
        cnt_d   = cnt_q + 1'b1;
      end
    end

    if (valid_q && ready) valid_d = 1'b0;

    if (ovr_clr) ovr_d = 1'b0;

    // A consume in the same cycle frees the slot for the new word.
    if (done) begin
      if (!valid_q || ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/dmux_deser4.sv
// Four-channel word assembler behind the 1:4 bit demux: select decode
// plus NCH independent lanes.
module dmux_deser4
  import dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   i,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NCH-1:0]         overrun,
  input  logic                   ovr_clr
);

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    logic bit_en;
    assign bit_en = in_valid && (sel == SEL_W'(n));

    dmux_deser_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .bit_en  (bit_en),
      .i       (i),
      .ready   (out_ready[n]),
      .ovr_clr (ovr_clr),
      .data    (out_data[n*WIDTH +: WIDTH]),
      .valid   (out_valid[n]),
      .overrun (overrun[n])
    );
  end

endmodule

// File: tb/tb_dmux_deser4.sv
// Directed test of dmux_deser4 with hand-computed expected values.
module tb_dmux_deser4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  sel;
  logic        i;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  overrun;
  logic        ovr_clr;

  int n_checks = 0;
  int n_fail   = 0;

  dmux_deser4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sel       (sel),
    .i         (i),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one bit, wait through the capturing edge to the next falling edge.
  task automatic send_bit(input logic [1:0] s, input logic b);
    sel = s; i = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [1:0] s, input logic [7:0] w, input int nb);
    for (int k = 0; k < nb; k++) send_bit(s, w[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; i = 1'b0;
    out_ready = 4'b0; ovr_clr = 1'b0;
    idle(2);
    check("rst_data",  out_data,  32'h0);
    check("rst_valid", {28'h0, out_valid}, 32'h0);
    check("rst_ovr",   {28'h0, overrun},   32'h0);
    rst = 1'b0;
    idle(1);

    // Single word A5 on lane 1
    send_bit(2'd1, 1); send_bit(2'd1, 0); send_bit(2'd1, 1); send_bit(2'd1, 0);
    send_bit(2'd1, 0); send_bit(2'd1, 1); send_bit(2'd1, 0);
    check("single_pre_valid", {28'h0, out_valid}, 32'h0);
    send_bit(2'd1, 1);
    check("single_valid", {28'h0, out_valid}, 32'h2);
    check("single_data",  out_data, 32'h0000A500);
    check("single_ovr",   {28'h0, overrun}, 32'h0);
    out_ready = 4'b0010;
    idle(1);
    out_ready = 4'b0;
    check("consume_valid", {28'h0, out_valid}, 32'h0);
    check("consume_hold",  out_data, 32'h0000A500);

    // Interleave 3C on lane 0 with F0 on lane 3
    for (int k = 0; k < 8; k++) begin
      logic [7:0] a, b;
      a = 8'h3C; b = 8'hF0;
      send_bit(2'd0, a[k]);
      if (k == 7) check("ilv_lane0_first", {28'h0, out_valid}, 32'h1);
      send_bit(2'd3, b[k]);
    end
    check("ilv_valid", {28'h0, out_valid}, 32'h9);
    check("ilv_data",  out_data, 32'hF000A53C);
    out_ready = 4'b1001;
    idle(1);
    out_ready = 4'b0;
    check("ilv_consumed", {28'h0, out_valid}, 32'h0);

    // Gaps: 81 on lane 2 with 3 idle cycles after bit 4
    send_bits(2'd2, 8'h81, 4);
    idle(3);
    send_bit(2'd2, 0); send_bit(2'd2, 0); send_bit(2'd2, 0);
    check("gap_pre_valid", {28'h0, out_valid}, 32'h0);
    send_bit(2'd2, 1);
    check("gap_valid", {28'h0, out_valid}, 32'h4);
    check("gap_data",  {24'h0, out_data[23:16]}, 32'h81);
    out_ready = 4'b0100;
    idle(1);
    out_ready = 4'b0;

    // Overrun on lane 0
    send_bits(2'd0, 8'h11, 8);
    check("ovr_first_valid", {28'h0, out_valid}, 32'h1);
    check("ovr_first_flag",  {28'h0, overrun},   32'h0);
    send_bits(2'd0, 8'h22, 8);
    check("ovr_kept_data", {24'h0, out_data[7:0]}, 32'h11);
    check("ovr_flag",      {28'h0, overrun},       32'h1);
    check("ovr_valid",     {28'h0, out_valid},     32'h1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_clr", {28'h0, overrun}, 32'h0);
    // Set wins over a coincident clear
    send_bits(2'd0, 8'h33, 7);
    ovr_clr = 1'b1;
    send_bit(2'd0, 0);
    ovr_clr = 1'b0;
    check("ovr_set_wins", {28'h0, overrun}, 32'h1);
    check("ovr_still_11", {24'h0, out_data[7:0]}, 32'h11);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    out_ready = 4'b0001;
    idle(1);
    out_ready = 4'b0;
    check("ovr_cleanup", {24'h0, out_valid, overrun}, 32'h0);

    // Back-to-back on lane 1 with consume on the completing cycle
    send_bits(2'd1, 8'h55, 8);
    check("b2b_first", {24'h0, out_data[15:8]}, 32'h55);
    send_bits(2'd1, 8'hAA, 7);
    out_ready = 4'b0010;
    send_bit(2'd1, 1);
    out_ready = 4'b0;
    check("b2b_valid", {28'h0, out_valid}, 32'h2);
    check("b2b_data",  {24'h0, out_data[15:8]}, 32'hAA);
    check("b2b_ovr",   {28'h0, overrun}, 32'h0);

    // Reset mid-word on lane 3; rst outranks a concurrent valid bit
    send_bits(2'd3, 8'hFF, 5);
    rst = 1'b1; in_valid = 1'b1; sel = 2'd3; i = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_data",  out_data, 32'h0);
    check("mid_rst_valid", {28'h0, out_valid}, 32'h0);
    check("mid_rst_ovr",   {28'h0, overrun},   32'h0);
    send_bits(2'd3, 8'h0F, 8);
    check("post_rst_data",  out_data, 32'h0F000000);
    check("post_rst_valid", {28'h0, out_valid}, 32'h8);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
